// File: rtl/mem_test_engine.sv
// Memory initiator for the heap-sort bench: FILL writes a reproducible LFSR
// sequence, CHECK reads it back, verifies non-decreasing signed order and sums it.
module mem_test_engine #(
  parameter logic [31:0] SEED = 32'hACE1_2345
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] base,
  input  logic [8:0]  count,
  output logic        busy,
  output logic        done,
  output logic        sorted,
  output logic [7:0]  err_idx,
  output logic [31:0] sum,
  output logic        we,
  output logic [31:0] a,
  output logic [31:0] wd,
  input  logic [31:0] rd
);

  typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

  state_t      state;
  logic [8:0]  count_q;
  logic [8:0]  idx;
  logic [31:0] lfsr;
  logic [31:0] prev;

  logic        last;
  logic        desc;
  logic [31:0] lfsr_adv;
  logic [31:0] base_aligned;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  assign base_aligned = base & ~32'd3;
  assign last         = (idx == count_q - 9'd1);
  assign lfsr_adv     = lfsr_next(lfsr);
  // First element has no predecessor, so it can never be a descending step.
  assign desc         = (idx != 9'd0) && ($signed(rd) < $signed(prev));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sorted  <= 1'b0;
      err_idx <= 8'd0;
      sum     <= 32'd0;
      we      <= 1'b0;
      a       <= 32'd0;
      wd      <= 32'd0;
      lfsr    <= SEED;
      count_q <= 9'd0;
      idx     <= 9'd0;
      prev    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            count_q <= count;
            idx     <= 9'd0;
            // A CHECK command owns the result registers from its start, even when empty.
            if (!op) begin
              sum     <= 32'd0;
              err_idx <= 8'd0;
              sorted  <= 1'b1;
              prev    <= 32'd0;
            end
            if (count == 9'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (op) begin
              state <= FILL;
              busy  <= 1'b1;
              we    <= 1'b1;
              a     <= base_aligned;
              wd    <= SEED;
              lfsr  <= SEED;
            end else begin
              state <= CHECK;
              busy  <= 1'b1;
              a     <= base_aligned;
            end
          end
        end

        FILL: begin
          lfsr <= lfsr_adv;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            we    <= 1'b0;
            a     <= 32'd0;
            wd    <= 32'd0;
          end else begin
            idx <= idx + 9'd1;
            a   <= a + 32'd4;
            wd  <= lfsr_adv;
          end
        end

        CHECK: begin
          sum  <= sum + rd;
          prev <= rd;
          if (desc && sorted) begin
            sorted  <= 1'b0;
            err_idx <= idx[7:0];
          end
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            a     <= 32'd0;
          end else begin
            idx <= idx + 9'd1;
            a   <= a + 32'd4;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_test_engine.md
# mem_test_engine

Self-checking memory initiator for the heap-sort testbench: drives the single-port word memory (`we`, `a`, `wd`, `rd`) from the master side. In FILL mode it writes a reproducible pseudo-random array. In CHECK mode it reads an array back, confirms it is in non-decreasing signed order and accumulates a checksum. It sits beside the core on the data-memory port and owns that port whenever `busy` is high.

## Interface
- `SEED`, 32'hACE1_2345, initial LFSR value reloaded at every FILL start; must be nonzero.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `op`  in  1  0 = CHECK, 1 = FILL; sampled with `start`.
- `base`  in  32  byte address of element 0; bits [1:0] ignored.
- `count`  in  9  number of words, 0..256; sampled with `start`.
- `busy`  out  1  high while in FILL or CHECK.
- `done`  out  1  one-cycle pulse when a command completes.
- `sorted`  out  1  CHECK result: 1 if no descending pair was found.
- `err_idx`  out  8  index i of the first element with `rd[i]` < `rd[i-1]` (signed compare).
- `sum`  out  32  CHECK result: sum of all words read, modulo 2^32.
- `we`  out  1  memory write enable.
- `a`  out  32  memory byte address, always word aligned.
- `wd`  out  32  memory write data.
- `rd`  in  32  memory read data, combinational from `a`.

## Operation
- States: IDLE, FILL, CHECK, DONE.
- IDLE, `start`=1:
  - Latch `op`, `base` & ~3, `count`; clear index i.
  - `count`=0 → DONE.
  - Otherwise `op`=1 → FILL, `op`=0 → CHECK.
- Entering FILL reloads the LFSR with `SEED`.
- Entering CHECK clears `sum` and `err_idx`, sets `sorted`=1 and clears the prev-valid flag.
- FILL, one word per cycle:
  - Drive `we`=1, `a`=base+4·i, `wd`=lfsr.
  - At the edge, advance the LFSR and increment i.
  - After word `count`-1 → DONE.
- LFSR: 32-bit Galois, right shift. Next value = (lfsr>>1) ^ (lfsr[0] ? 32'h8020_0003 : 0).
- CHECK, one word per cycle:
  - Drive `we`=0, `a`=base+4·i.
  - At the edge: `sum` += `rd`.
  - If i>0 and $signed(`rd`) < $signed(prev) and `sorted`=1: set `sorted`=0 and `err_idx`=i.
  - Then prev=`rd`, increment i.
  - Only the first failure is recorded; the scan always continues to the end so `sum` is complete.
  - After word `count`-1 → DONE.
- DONE: `done`=1 for exactly one cycle, then → IDLE.
- Address arithmetic wraps modulo 2^32.
- `count`=256 is legal; the index counter is 9 bits wide.
- Outside FILL: `we`=0, `wd`=0. Outside FILL/CHECK: `a`=0.
- `sorted`, `err_idx` and `sum` hold their value until the next CHECK start. FILL leaves them untouched.
- `start` while not in IDLE (including DONE) is ignored.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `sorted`=0, `err_idx`=0, `sum`=0, `we`=0, `a`=0, `wd`=0, LFSR=`SEED`.
- `start` sampled at edge 0:
  - Memory accesses occur in cycles 1..`count`.
  - `done` is high in cycle `count`+1.
  - `busy` is high in cycles 1..`count`.
- `count`=0: `done` is high in cycle 1, with no memory access and `busy` never asserted.
- FILL writes commit at the rising edge that ends each access cycle.
- CHECK samples `rd` at that same edge. This supports zero read latency only.
- Results are valid in the `done` cycle.
- Reset asserted mid-command: at that edge return to IDLE with all outputs at reset values. `we` is low from that edge on. Partially written memory is left as is.

## Test plan
- FILL, `base`=0x40, `count`=4, then read memory directly:
  - Words 0x40, 0x44, 0x48, 0x4C equal `SEED` and the next three LFSR values.
  - `done` is high in cycle 5.
  - `we` is high in cycles 1..4 only.
- CHECK on [1, 2, 2, 5] at `base`=0:
  - `sorted`=1, `sum`=10, `err_idx`=0.
  - `done` is high in cycle 5.
- CHECK on [3, 1, 0, 7]: `sorted`=0, `err_idx`=1 (first failure only), `sum`=11.
- CHECK on [0xFFFFFFFB (-5), 3] → `sorted`=1 (signed compare). CHECK on [3, 0xFFFFFFFB] → `sorted`=0, `err_idx`=1, `sum`=0xFFFFFFFE.
- `count`=0 → `done` in cycle 1, `sorted`=1, `sum`=0, no memory access. Also: `start` pulsed while `busy` is high is ignored, and results are unchanged.
- Reset asserted in cycle 2 of a `count`=8 FILL:
  - Only words 0 and 1 are written.
  - All outputs are at reset values from the next cycle.
  - A following FILL restarts from `SEED`.
